// File: rtl/stream_config_pkg.sv
// rtl/stream_config_pkg.sv - shared types and constants for stream reconfiguration
package stream_config_pkg;

  localparam int DEFAULT_TYPE_WIDTH = 4;

  typedef logic [DEFAULT_TYPE_WIDTH-1:0] type_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_BAD_ID  = 2'b10
  } err_t;

  // Each stream owns a select register followed by a data-type register.
  localparam int REGS_PER_STREAM = 2;
  localparam int SELECT_OFFSET   = 0;
  localparam int TYPE_OFFSET     = 1;

  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_config_sequencer_if.sv
// rtl/stream_config_sequencer_if.sv - command, pause/idle, config-write and status bundle
interface stream_config_sequencer_if #(
  parameter int NUM_SELECT      = 4,
  parameter int NUM_STREAMS     = 4,
  parameter int TYPE_WIDTH      = 4,
  parameter int CONF_DATA_WIDTH = 64
);
  import stream_config_pkg::*;

  localparam int SELECT_WIDTH = min_width(NUM_SELECT);
  localparam int ID_WIDTH     = min_width(NUM_STREAMS);
  localparam int ADDR_WIDTH   = $clog2(REGS_PER_STREAM * NUM_STREAMS);

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [ID_WIDTH-1:0]        cmd_id;
  logic [SELECT_WIDTH-1:0]    cmd_select;
  logic [TYPE_WIDTH-1:0]      cmd_type;

  logic [NUM_STREAMS-1:0]     pause;
  logic [NUM_STREAMS-1:0]     idle;

  logic                       conf_valid;
  logic                       conf_ready;
  logic [ADDR_WIDTH-1:0]      conf_addr;
  logic [CONF_DATA_WIDTH-1:0] conf_data;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_WIDTH-1:0]        rsp_id;
  err_t                       rsp_error;

  // The sequencer side: it masters pause, the config bus and the status channel.
  modport master (
    input  cmd_valid, cmd_id, cmd_select, cmd_type,
    output cmd_ready,
    output pause,
    input  idle,
    output conf_valid, conf_addr, conf_data,
    input  conf_ready,
    output rsp_valid, rsp_id, rsp_error,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_id, cmd_select, cmd_type,
    input  cmd_ready,
    input  pause,
    output idle,
    input  conf_valid, conf_addr, conf_data,
    output conf_ready,
    input  rsp_valid, rsp_id, rsp_error,
    output rsp_ready
  );

endinterface

// File: rtl/stream_quiesce_timer.sv
// rtl/stream_quiesce_timer.sv - bounded wait for a paused stream to drain
module stream_quiesce_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic idle,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;
  logic          running;

  // Loaded with TIMEOUT_CYCLES-1 so expiry lands on the last permitted wait cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= CW'(TIMEOUT_CYCLES - 1);
      running <= 1'b1;
    end else if (running && !idle && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = running && !idle && (count == '0);

endmodule

// File: rtl/stream_config_sequencer.sv
// rtl/stream_config_sequencer.sv - pause a stream, rewrite its select/type registers, report status
module stream_config_sequencer #(
  parameter int NUM_SELECT      = 4,
  parameter int NUM_STREAMS     = 4,
  parameter int TYPE_WIDTH      = 4,
  parameter int CONF_DATA_WIDTH = 64,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic                        clk,
  input logic                        rst,
  stream_config_sequencer_if.master  bus
);
  import stream_config_pkg::*;

  localparam int SELECT_WIDTH = min_width(NUM_SELECT);
  localparam int ID_WIDTH     = min_width(NUM_STREAMS);
  localparam int ADDR_WIDTH   = $clog2(REGS_PER_STREAM * NUM_STREAMS);

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    WR_SEL,
    WR_TYPE,
    RESP
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ID_WIDTH-1:0]     id_q;
  logic [SELECT_WIDTH-1:0] select_q;
  logic [TYPE_WIDTH-1:0]   type_q;
  err_t                    err_q;
  err_t                    err_next;

  logic                    bad_id;
  logic                    stream_idle;
  logic                    timer_start;
  logic                    timer_clear;
  logic                    timer_expired;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [ADDR_WIDTH-1:0]   type_addr;

  assign bad_id      = int'(bus.cmd_id) >= NUM_STREAMS;
  assign stream_idle = bus.idle[id_q];
  assign sel_addr    = ADDR_WIDTH'(REGS_PER_STREAM * int'(id_q) + SELECT_OFFSET);
  assign type_addr   = ADDR_WIDTH'(REGS_PER_STREAM * int'(id_q) + TYPE_OFFSET);

  stream_quiesce_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .clear  (timer_clear),
    .idle   (stream_idle),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      id_q     <= '0;
      select_q <= '0;
      type_q   <= '0;
      err_q    <= ERR_OK;
    end else begin
      state <= state_next;
      err_q <= err_next;
      if (state == IDLE && bus.cmd_valid) begin
        id_q     <= bus.cmd_id;
        select_q <= bus.cmd_select;
        type_q   <= bus.cmd_type;
      end
    end
  end

  // Outputs decode from state and latched fields only, so they hold under backpressure.
  always_comb begin
    state_next     = state;
    err_next       = err_q;
    timer_start    = 1'b0;
    timer_clear    = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.pause      = '0;
    bus.conf_valid = 1'b0;
    bus.conf_addr  = '0;
    bus.conf_data  = '0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_id     = '0;
    bus.rsp_error  = ERR_OK;

    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (bad_id) begin
            state_next = RESP;
            err_next   = ERR_BAD_ID;
          end else begin
            state_next  = QUIESCE;
            timer_start = 1'b1;
          end
        end
      end

      QUIESCE: begin
        bus.pause = NUM_STREAMS'(1) << id_q;
        if (stream_idle) begin
          state_next  = WR_SEL;
          timer_clear = 1'b1;
        end else if (timer_expired) begin
          state_next  = RESP;
          err_next    = ERR_TIMEOUT;
          timer_clear = 1'b1;
        end
      end

      WR_SEL: begin
        bus.pause      = NUM_STREAMS'(1) << id_q;
        bus.conf_valid = 1'b1;
        bus.conf_addr  = sel_addr;
        bus.conf_data  = CONF_DATA_WIDTH'(select_q);
        if (bus.conf_ready) begin
          state_next = WR_TYPE;
        end
      end

      WR_TYPE: begin
        bus.pause      = NUM_STREAMS'(1) << id_q;
        bus.conf_valid = 1'b1;
        bus.conf_addr  = type_addr;
        bus.conf_data  = CONF_DATA_WIDTH'(type_q);
        if (bus.conf_ready) begin
          state_next = RESP;
          err_next   = ERR_OK;
        end
      end

      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = id_q;
        bus.rsp_error = err_q;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_config_sequencer.sv
// tb/tb_stream_config_sequencer.sv - directed bench with a transaction-level reference model
module tb_stream_config_sequencer;
  import stream_config_pkg::*;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       cmd_valid  = 1'b0;
  logic [1:0] cmd_id     = '0;
  logic [1:0] cmd_select = '0;
  logic [3:0] cmd_type   = '0;
  logic [3:0] idle       = '0;
  logic       conf_ready = 1'b1;
  logic       rsp_ready  = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // dut0: default 4 streams / 1024-cycle timeout; dut1: 3 streams / 8-cycle timeout.
  stream_config_sequencer_if #(.NUM_STREAMS(4)) bus0 ();
  stream_config_sequencer_if #(.NUM_STREAMS(3)) bus1 ();

  assign bus0.cmd_valid  = cmd_valid;
  assign bus0.cmd_id     = cmd_id;
  assign bus0.cmd_select = cmd_select;
  assign bus0.cmd_type   = cmd_type;
  assign bus0.idle       = idle;
  assign bus0.conf_ready = conf_ready;
  assign bus0.rsp_ready  = rsp_ready;
  assign bus1.cmd_valid  = cmd_valid;
  assign bus1.cmd_id     = cmd_id;
  assign bus1.cmd_select = cmd_select;
  assign bus1.cmd_type   = cmd_type;
  assign bus1.idle       = idle[2:0];
  assign bus1.conf_ready = conf_ready;
  assign bus1.rsp_ready  = rsp_ready;

  stream_config_sequencer #(.NUM_STREAMS(4), .TIMEOUT_CYCLES(1024)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  stream_config_sequencer #(.NUM_STREAMS(3), .TIMEOUT_CYCLES(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding command per instance, tracked as progress counters.
  int  ns  [2] = '{4, 3};
  int  tmo [2] = '{1024, 8};
  bit  m_ok [2];
  bit  m_active [2];
  bit  m_resp [2];
  bit  m_drained [2];
  int  m_wait [2];
  int  m_writes [2];
  int  m_id [2];
  int  m_sel [2];
  int  m_type [2];
  int  m_err [2];

  logic        o_cmd_ready  [2];
  logic [3:0]  o_pause      [2];
  logic        o_conf_valid [2];
  logic [2:0]  o_conf_addr  [2];
  logic [63:0] o_conf_data  [2];
  logic        o_rsp_valid  [2];
  logic [1:0]  o_rsp_id     [2];
  logic [1:0]  o_rsp_error  [2];

  task automatic model_check(input int k);
    logic [3:0] exp_pause;
    bit         exp_cv;
    exp_pause = (m_active[k] && !m_resp[k]) ? 4'(1 << m_id[k]) : 4'd0;
    exp_cv    = m_active[k] && !m_resp[k] && m_drained[k];
    chk($sformatf("dut%0d cmd_ready", k), o_cmd_ready[k], !m_active[k]);
    chk($sformatf("dut%0d pause", k), o_pause[k], exp_pause);
    chk($sformatf("dut%0d conf_valid", k), o_conf_valid[k], exp_cv);
    if (exp_cv) begin
      chk($sformatf("dut%0d conf_addr", k), o_conf_addr[k], 2 * m_id[k] + m_writes[k]);
      chk($sformatf("dut%0d conf_data", k), o_conf_data[k],
          (m_writes[k] == 0) ? m_sel[k] : m_type[k]);
    end
    chk($sformatf("dut%0d rsp_valid", k), o_rsp_valid[k], m_resp[k]);
    if (m_resp[k]) begin
      chk($sformatf("dut%0d rsp_id", k), o_rsp_id[k], m_id[k]);
      chk($sformatf("dut%0d rsp_error", k), o_rsp_error[k], m_err[k]);
    end
  endtask

  task automatic model_step(input int k);
    if (rst) begin
      m_ok[k]     = 1'b1;
      m_active[k] = 1'b0;
      m_resp[k]   = 1'b0;
      m_drained[k] = 1'b0;
    end else if (m_ok[k]) begin
      if (!m_active[k]) begin
        if (cmd_valid) begin
          m_active[k] = 1'b1;
          m_id[k]     = int'(cmd_id);
          m_sel[k]    = int'(cmd_select);
          m_type[k]   = int'(cmd_type);
          m_drained[k] = 1'b0;
          m_wait[k]   = 0;
          if (m_id[k] >= ns[k]) begin
            m_resp[k] = 1'b1;
            m_err[k]  = 2;
          end
        end
      end else if (m_resp[k]) begin
        if (rsp_ready) begin
          m_active[k] = 1'b0;
          m_resp[k]   = 1'b0;
        end
      end else if (!m_drained[k]) begin
        if (idle[m_id[k]]) begin
          m_drained[k] = 1'b1;
          m_writes[k]  = 0;
        end else if (m_wait[k] == tmo[k] - 1) begin
          m_resp[k] = 1'b1;
          m_err[k]  = 1;
        end else begin
          m_wait[k]++;
        end
      end else if (conf_ready) begin
        m_writes[k]++;
        if (m_writes[k] == 2) begin
          m_resp[k] = 1'b1;
          m_err[k]  = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    o_cmd_ready[0]  = bus0.cmd_ready;
    o_pause[0]      = bus0.pause;
    o_conf_valid[0] = bus0.conf_valid;
    o_conf_addr[0]  = bus0.conf_addr;
    o_conf_data[0]  = bus0.conf_data;
    o_rsp_valid[0]  = bus0.rsp_valid;
    o_rsp_id[0]     = bus0.rsp_id;
    o_rsp_error[0]  = bus0.rsp_error;
    o_cmd_ready[1]  = bus1.cmd_ready;
    o_pause[1]      = {1'b0, bus1.pause};
    o_conf_valid[1] = bus1.conf_valid;
    o_conf_addr[1]  = bus1.conf_addr;
    o_conf_data[1]  = bus1.conf_data;
    o_rsp_valid[1]  = bus1.rsp_valid;
    o_rsp_id[1]     = bus1.rsp_id;
    o_rsp_error[1]  = bus1.rsp_error;
    for (int k = 0; k < 2; k++) begin
      if (m_ok[k]) model_check(k);
      model_step(k);
    end
  end

  task automatic send_cmd(input int id, input int sel, input int typ);
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_id     = 2'(id);
    cmd_select = 2'(sel);
    cmd_type   = 4'(typ);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus0.cmd_ready && bus1.cmd_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " back to idle"}, bus0.cmd_ready && bus1.cmd_ready, 1'b1);
  endtask

  initial begin
    // Reset and reset values.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset cmd_ready0", bus0.cmd_ready, 1'b1);
    chk("reset cmd_ready1", bus1.cmd_ready, 1'b1);
    chk("reset pause0", bus0.pause, 4'b0000);
    chk("reset conf_valid0", bus0.conf_valid, 1'b0);
    chk("reset conf_addr0", bus0.conf_addr, 3'd0);
    chk("reset conf_data0", bus0.conf_data, 64'd0);
    chk("reset rsp_valid0", bus0.rsp_valid, 1'b0);
    chk("reset rsp_id0", bus0.rsp_id, 2'd0);
    chk("reset rsp_error0", bus0.rsp_error, 2'b00);

    // Nominal: id 2, select 3, type 5.
    idle = 4'b0100; conf_ready = 1'b1; rsp_ready = 1'b1;
    send_cmd(2, 3, 5);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) chk("nom pause c1", bus0.pause, 4'b0100);
      if (c == 1) chk("nom conf_valid c1", bus0.conf_valid, 1'b0);
      if (c == 2) chk("nom sel write", {bus0.conf_valid, bus0.conf_addr, bus0.conf_data[3:0]}, {1'b1, 3'd4, 4'd3});
      if (c == 3) chk("nom type write", {bus0.conf_valid, bus0.conf_addr, bus0.conf_data[3:0]}, {1'b1, 3'd5, 4'd5});
      if (c == 4) chk("nom rsp", {bus0.rsp_valid, bus0.rsp_id, 2'(bus0.rsp_error)}, {1'b1, 2'd2, 2'b00});
      if (c == 4) chk("nom pause released", bus0.pause, 4'b0000);
      if (c == 5) chk("nom cmd_ready c5", bus0.cmd_ready, 1'b1);
      @(posedge clk); #1;
    end
    wait_idle("nominal");

    // Backpressure: conf_ready low three cycles ahead of each write handshake.
    idle = 4'b0001;
    conf_ready = 1'b0;
    send_cmd(0, 1, 9);
    for (int c = 1; c <= 10; c++) begin
      conf_ready = (c == 5 || c == 9);
      @(negedge clk);
      if (c <= 9) chk("bp pause held", bus0.pause, 4'b0001);
      if (c >= 2 && c <= 5) chk("bp sel stable", {bus0.conf_valid, bus0.conf_addr, bus0.conf_data[3:0]}, {1'b1, 3'd0, 4'd1});
      if (c >= 6 && c <= 9) chk("bp type stable", {bus0.conf_valid, bus0.conf_addr, bus0.conf_data[3:0]}, {1'b1, 3'd1, 4'd9});
      if (c == 9) chk("bp rsp not early", bus0.rsp_valid, 1'b0);
      if (c == 10) chk("bp rsp c10", {bus0.rsp_valid, 2'(bus0.rsp_error)}, {1'b1, 2'b00});
      @(posedge clk); #1;
    end
    conf_ready = 1'b1;
    wait_idle("backpressure");

    // Slow drain on dut0 (idle[1] at cycle 21); dut1 times out after 8 wait cycles.
    idle = 4'b0000;
    send_cmd(1, 2, 6);
    for (int c = 1; c <= 25; c++) begin
      idle = (c >= 21) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (c == 21) chk("drain no write yet", bus0.conf_valid, 1'b0);
      if (c == 21) chk("drain pause held", bus0.pause, 4'b0010);
      if (c == 22) chk("drain sel write", {bus0.conf_valid, bus0.conf_addr, bus0.conf_data[3:0]}, {1'b1, 3'd2, 4'd2});
      if (c == 23) chk("drain type write", {bus0.conf_valid, bus0.conf_addr, bus0.conf_data[3:0]}, {1'b1, 3'd3, 4'd6});
      if (c == 24) chk("drain rsp", {bus0.rsp_valid, bus0.rsp_id, 2'(bus0.rsp_error)}, {1'b1, 2'd1, 2'b00});
      if (c <= 9) chk("tmo8 no write", bus1.conf_valid, 1'b0);
      if (c == 8) chk("tmo8 still waiting", {bus1.rsp_valid, bus1.pause}, {1'b0, 3'b010});
      if (c == 9) chk("tmo8 rsp c9", {bus1.rsp_valid, bus1.rsp_id, 2'(bus1.rsp_error)}, {1'b1, 2'd1, 2'b01});
      if (c == 9) chk("tmo8 pause low", bus1.pause, 3'b000);
      @(posedge clk); #1;
    end
    idle = 4'b0000;
    wait_idle("slow drain");

    // Full-length timeout on dut0 with idle held low.
    send_cmd(0, 3, 15);
    for (int c = 1; c <= 1025; c++) begin
      @(negedge clk);
      if (c == 1024) chk("tmo1024 waiting", {bus0.rsp_valid, bus0.pause}, {1'b0, 4'b0001});
      if (c == 1025) chk("tmo1024 rsp", {bus0.rsp_valid, 2'(bus0.rsp_error)}, {1'b1, 2'b01});
      @(posedge clk); #1;
    end
    wait_idle("timeout");

    // Idle arriving on the last permitted wait cycle of dut1 still wins.
    send_cmd(0, 2, 4);
    for (int c = 1; c <= 12; c++) begin
      idle = (c >= 8) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (c == 9) chk("edge sel write", {bus1.conf_valid, bus1.conf_addr, bus1.rsp_valid}, {1'b1, 3'd0, 1'b0});
      if (c == 11) chk("edge rsp ok", {bus1.rsp_valid, 2'(bus1.rsp_error)}, {1'b1, 2'b00});
      @(posedge clk); #1;
    end
    idle = 4'b0000;
    wait_idle("timeout edge");

    // Bad id on dut1 (3 streams); dut0 treats id 3 as valid. Status held under rsp backpressure.
    idle = 4'b1111;
    rsp_ready = 1'b0;
    send_cmd(3, 1, 2);
    for (int c = 1; c <= 5; c++) begin
      rsp_ready = (c >= 4);
      @(negedge clk);
      if (c == 1) chk("badid rsp c1", {bus1.rsp_valid, bus1.rsp_id, 2'(bus1.rsp_error)}, {1'b1, 2'd3, 2'b10});
      if (c <= 3) chk("badid no pause", {bus1.pause, bus1.conf_valid}, {3'b000, 1'b0});
      if (c == 3) chk("badid rsp held", {bus1.rsp_valid, 2'(bus1.rsp_error)}, {1'b1, 2'b10});
      if (c == 1) chk("id3 pause dut0", bus0.pause, 4'b1000);
      if (c == 4) chk("id3 rsp dut0", {bus0.rsp_valid, bus0.rsp_id, 2'(bus0.rsp_error)}, {1'b1, 2'd3, 2'b00});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    idle = 4'b0000;
    wait_idle("bad id");

    // Reset while stalled in the type write, then a clean command.
    idle = 4'b0100;
    send_cmd(2, 1, 3);
    for (int c = 1; c <= 4; c++) begin
      conf_ready = (c != 3);
      rst = (c == 3);
      @(negedge clk);
      if (c == 3) chk("rst in type write", {bus0.conf_valid, bus0.conf_addr}, {1'b1, 3'd5});
      if (c == 4) chk("rst outputs0", {bus0.cmd_ready, bus0.pause, bus0.conf_valid, bus0.conf_addr, bus0.rsp_valid, bus0.rsp_id, 2'(bus0.rsp_error)},
                      {1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0, 2'b00});
      if (c == 4) chk("rst conf_data0", bus0.conf_data, 64'd0);
      if (c == 4) chk("rst outputs1", {bus1.cmd_ready, bus1.pause, bus1.conf_valid, bus1.rsp_valid}, {1'b1, 3'b000, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    rst = 1'b0;
    conf_ready = 1'b1;
    idle = 4'b0010;
    send_cmd(1, 2, 7);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) chk("post-rst sel write", {bus0.conf_addr, bus0.conf_data[3:0]}, {3'd2, 4'd2});
      if (c == 3) chk("post-rst type write", {bus1.conf_addr, bus1.conf_data[3:0]}, {3'd3, 4'd7});
      if (c == 4) chk("post-rst rsp", {bus0.rsp_valid, bus0.rsp_id, 2'(bus0.rsp_error)}, {1'b1, 2'd1, 2'b00});
      @(posedge clk); #1;
    end
    wait_idle("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
